// File: rtl/booth_mult_seq_if.sv
// Handshake bundle between the issuing control logic and the sequential Booth multiplier.
interface booth_mult_seq_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] P;
  logic        busy;
  logic        done;

  modport master (output start, output A, output B, input P, input busy, input done);
  modport slave  (input start, input A, input B, output P, output busy, output done);
endinterface

// File: rtl/booth_mult_seq.sv
// Radix-2 Booth 16x16 signed multiplier: one twos_comp add/sub per cycle, then an
// arithmetic right shift of {ACC, Q, q1}; product lands in P after 16 iterations.
module booth_mult_seq (
  input  logic                   clk,
  input  logic                   rst,
  booth_mult_seq_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] m_q, m_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] qr_q, qr_d;
  logic        q1_q, q1_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] p_q, p_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sub_en_s;
  logic        use_res_s;
  logic [15:0] tc_out_s;
  logic        tc_ovf_s;
  logic        cout_unused;
  logic [15:0] res_s;
  logic        sign_s;

  twos_comp u_tc (
    .A        (acc_q),
    .B        (m_q),
    .sub_en   (sub_en_s),
    .OUT      (tc_out_s),
    .Cout     (cout_unused),
    .overflow (tc_ovf_s)
  );

  // Booth pair decode and true-sign recovery of the selected partial sum.
  always_comb begin
    sub_en_s  = 1'b0;
    use_res_s = 1'b0;
    case ({qr_q[0], q1_q})
      2'b01: begin
        sub_en_s  = 1'b0;
        use_res_s = 1'b1;
      end
      2'b10: begin
        sub_en_s  = 1'b1;
        use_res_s = 1'b1;
      end
      default: begin
        sub_en_s  = 1'b0;
        use_res_s = 1'b0;
      end
    endcase
    if (use_res_s) begin
      res_s  = tc_out_s;
      sign_s = tc_out_s[15] ^ tc_ovf_s;
    end else begin
      res_s  = acc_q;
      sign_s = acc_q[15];
    end
  end

  // Next-state and next-register computation for the controller.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = bus.A;
          qr_d    = bus.B;
          acc_d   = 16'd0;
          q1_d    = 1'b0;
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        acc_d = {sign_s, res_s[15:1]};
        qr_d  = {res_s[0], qr_q[15:1]};
        q1_d  = qr_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          p_d     = {sign_s, res_s, qr_q[15:1]};
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any multiply and clears P.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= 16'd0;
      acc_q   <= 16'd0;
      qr_q    <= 16'd0;
      q1_q    <= 1'b0;
      cnt_q   <= 5'd0;
      p_q     <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.P    = p_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// 16-bit two's-complement add/subtract: OUT = A + B or A - B, with signed overflow.
module twos_comp (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sub_en,
  output logic [15:0] OUT,
  output logic        Cout,
  output logic        overflow
);
  logic [15:0] b_eff_s;
  logic [16:0] sum_s;

  // Subtract is add of the inverted operand with carry-in.
  always_comb begin
    b_eff_s  = B ^ {16{sub_en}};
    sum_s    = {1'b0, A} + {1'b0, b_eff_s} + {16'd0, sub_en};
    OUT      = sum_s[15:0];
    Cout     = sum_s[16];
    overflow = (A[15] == b_eff_s[15]) && (sum_s[15] != A[15]);
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: products, handshake timing, ignored starts, async reset.
module tb_booth_mult_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  booth_mult_seq_if bus ();

  booth_mult_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full operation with a one-cycle start pulse; checks every handshake milestone.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p);
    logic [31:0] done_seen;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();                                   // accept edge t0
    bus.start = 1'b0;
    check({tag, "_busy_t0"}, {31'd0, bus.busy}, 32'd1);
    done_seen = 32'd0;
    for (int i = 0; i < 15; i++) begin
      tick();
      done_seen = done_seen | {31'd0, bus.done};
    end
    check({tag, "_done_early"}, done_seen, 32'd0);
    tick();                                   // t0+16
    check({tag, "_done_t16"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_busy_t16"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_P"}, bus.P, exp_p);
    tick();                                   // t0+17
    check({tag, "_done_t17"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_busy_t17"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_P_hold"}, bus.P, exp_p);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = 16'd0;
    bus.B     = 16'd0;
    #2;
    check("rst_P", bus.P, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    run_mul("m3x5", 16'd3, 16'd5, 32'h0000_000F);
    run_mul("mn7x6", 16'hFFF9, 16'd6, 32'hFFFF_FFD6);
    run_mul("m6xn7", 16'd6, 16'hFFF9, 32'hFFFF_FFD6);
    run_mul("m8000sq", 16'h8000, 16'h8000, 32'h4000_0000);
    run_mul("m7fffx8000", 16'h7FFF, 16'h8000, 32'hC000_8000);
    run_mul("m0x1234", 16'h0000, 16'h1234, 32'h0000_0000);

    // Starts during RUN and DONE are ignored; held start accepts at t0+18.
    bus.A     = 16'd2;
    bus.B     = 16'd9;
    bus.start = 1'b1;
    tick();                                   // t0
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();       // t0+4
    bus.A     = 16'd100;
    bus.B     = 16'd100;
    bus.start = 1'b1;
    tick();                                   // t0+5, RUN
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();      // t0+15
    check("ign_busy_t15", {31'd0, bus.busy}, 32'd1);
    tick();                                   // t0+16
    check("ign_done", {31'd0, bus.done}, 32'd1);
    check("ign_P", bus.P, 32'h0000_0012);
    bus.start = 1'b1;                         // held from DONE onward
    tick();                                   // t0+17
    check("hold_busy_t17", {31'd0, bus.busy}, 32'd0);
    check("hold_done_t17", {31'd0, bus.done}, 32'd0);
    check("hold_P_t17", bus.P, 32'h0000_0012);
    tick();                                   // t0+18 accept
    check("hold_busy_t18", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 16; i++) tick();      // t0+34
    check("hold_done", {31'd0, bus.done}, 32'd1);
    check("hold_P", bus.P, 32'h0000_2710);
    bus.start = 1'b0;
    tick();
    check("hold_busy_end", {31'd0, bus.busy}, 32'd0);

    // Async reset mid-RUN aborts and clears P without a clock edge.
    run_mul("pre_rst", 16'd3, 16'd5, 32'h0000_000F);
    bus.A     = 16'd11;
    bus.B     = 16'd13;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_P", bus.P, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    run_mul("m11x13", 16'd11, 16'd13, 32'h0000_008F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
